data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: puts aligned loads and stores onto the memory bus,
// bounds the wait for bus_ack, and registers the MEM/WB write-back outputs.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_memrw,
  input  logic [31:0] mem_memaddr,
  input  logic [31:0] mem_memdata,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_we,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_waddr,
  output logic        wb_we,
  output logic        mem_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d;
  logic [4:0]    wb_waddr_q, wb_waddr_d;
  logic          wb_we_q, wb_we_d;
  logic          mem_err_q, mem_err_d;
  logic          abort_q, abort_d;
  logic [31:0]   load_q, load_d;

  logic is_access, aligned, misaligned;

  assign is_access  = (mem_memrw == 2'b01) || (mem_memrw == 2'b10);
  assign aligned    = is_access && (mem_memaddr[1:0] == 2'b00);
  assign misaligned = is_access && (mem_memaddr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wb_wdata_d  = wb_wdata_q;
    wb_waddr_d  = wb_waddr_q;
    wb_we_d     = wb_we_q;
    mem_err_d   = 1'b0;
    abort_d     = abort_q;
    load_d      = load_q;
    stallreq    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (aligned) begin
          stallreq    = 1'b1;
          state_d     = S_BUS;
          bus_req_d   = 1'b1;
          bus_we_d    = (mem_memrw == 2'b10);
          bus_addr_d  = mem_memaddr;
          bus_wdata_d = mem_memdata;
          cnt_d       = '0;
        end else if (misaligned) begin
          wb_we_d     = 1'b0;
          wb_waddr_d  = mem_waddr;
          wb_wdata_d  = '0;
          mem_err_d   = 1'b1;
        end else begin
          wb_wdata_d  = mem_wdata;
          wb_waddr_d  = mem_waddr;
          wb_we_d     = mem_we;
        end
      end
      S_BUS: begin
        stallreq = 1'b1;
        // An ack in the last allowed cycle wins over the timeout.
        if (bus_ack) begin
          load_d    = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          abort_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        wb_waddr_d = mem_waddr;
        if (abort_q) begin
          wb_we_d    = 1'b0;
          wb_wdata_d = '0;
          mem_err_d  = 1'b1;
          abort_d    = 1'b0;
        end else if (bus_we_q) begin
          wb_wdata_d = mem_wdata;
          wb_we_d    = mem_we;
        end else begin
          wb_wdata_d = load_q;
          wb_we_d    = mem_we;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) stallreq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wb_wdata_q  <= '0;
      wb_waddr_q  <= '0;
      wb_we_q     <= 1'b0;
      mem_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      load_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_we_q     <= wb_we_d;
      mem_err_q   <= mem_err_d;
      abort_q     <= abort_d;
      load_q      <= load_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_wdata  = wb_wdata_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_we     = wb_we_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected write-back, error and latency figures are
// queued when a request is driven and compared when the stage releases the stall.
module tb_data_mem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_memrw;
  logic [31:0] mem_memaddr, mem_memdata, mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic        stallreq, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_we, mem_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_memrw(mem_memrw), .mem_memaddr(mem_memaddr), .mem_memdata(mem_memdata),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_wdata(wb_wdata), .wb_waddr(wb_waddr), .wb_we(wb_we), .mem_err(mem_err)
  );

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        we;
    logic        err;
    int          stall;
    int          breq;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] rw, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] waddr,
                                 input logic we, input int k, input logic [31:0] rdata);
    exp_t e;
    logic acc, al, tmo;
    acc = (rw == 2'b01) || (rw == 2'b10);
    al  = acc && (addr[1:0] == 2'b00);
    tmo = al && (k < 0 || k > TIMEOUT - 1);
    e.waddr = waddr;
    e.err   = 1'b0;
    e.stall = 0;
    e.breq  = 0;
    if ((acc && !al) || tmo) begin
      e.wdata = '0;
      e.we    = 1'b0;
      e.err   = 1'b1;
    end else if (al && rw == 2'b01) begin
      e.wdata = rdata;
      e.we    = we;
    end else begin
      e.wdata = wdata;
      e.we    = we;
    end
    if (al) begin
      e.stall = tmo ? TIMEOUT + 1 : k + 2;
      e.breq  = tmo ? TIMEOUT : k + 1;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge, ready for the next request.
  task automatic run_txn(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] mdata,
                         input logic [31:0] wdata, input logic [4:0] waddr, input logic we,
                         input int k, input logic [31:0] rdata);
    exp_t e;
    int   stall_n = 0;
    int   breq_n = 0;
    bit   done = 0;
    sb_q.push_back(model(rw, addr, wdata, waddr, we, k, rdata));
    mem_memrw   = rw;
    mem_memaddr = addr;
    mem_memdata = mdata;
    mem_wdata   = wdata;
    mem_waddr   = waddr;
    mem_we      = we;
    bus_rdata   = rdata;
    #1;
    for (int c = 0; c < 100 && !done; c++) begin
      if (bus_req) begin
        breq_n++;
        check("bus_we", 32'(bus_we), 32'(rw == 2'b10));
        check("bus_addr", bus_addr, addr);
        check("bus_wdata", bus_wdata, mdata);
        bus_ack = (k >= 0) && (breq_n - 1 == k);
      end else begin
        bus_ack = 1'b0;
      end
      if (stallreq) stall_n++;
      else done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) check("wait_budget", 32'(stallreq), 32'd0);
    e = sb_q.pop_front();
    check("wb_wdata", wb_wdata, e.wdata);
    check("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
    check("wb_we", 32'(wb_we), 32'(e.we));
    check("mem_err", 32'(mem_err), 32'(e.err));
    check("stall_cycles", 32'(stall_n), 32'(e.stall));
    check("bus_req_cycles", 32'(breq_n), 32'(e.breq));
    bus_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_memrw = 2'b00; mem_memaddr = '0; mem_memdata = '0;
    mem_wdata = '0; mem_waddr = '0; mem_we = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(2'b00, 32'h0,  32'h0,        32'hA5A5A5A5, 5'd3,  1'b1, 0,  32'h0);
    run_txn(2'b01, 32'h10, 32'h0,        32'h0,        5'd5,  1'b1, 1,  32'hDEADBEEF);
    run_txn(2'b10, 32'h20, 32'h12345678, 32'h0BADF00D, 5'd7,  1'b1, 0,  32'h0);
    run_txn(2'b01, 32'h30, 32'h0,        32'h0,        5'd9,  1'b1, -1, 32'h77777777);
    run_txn(2'b01, 32'h3,  32'h0,        32'h00000055, 5'd4,  1'b1, 0,  32'h0);
    run_txn(2'b11, 32'h44, 32'h0,        32'h11112222, 5'd31, 1'b1, 0,  32'h0);
    run_txn(2'b01, 32'h48, 32'h0,        32'h0,        5'd6,  1'b1, 15, 32'hCAFEF00D);
    run_txn(2'b10, 32'h22, 32'h99999999, 32'h0,        5'd8,  1'b1, 0,  32'h0);
    run_txn(2'b01, 32'h4C, 32'h0,        32'h0,        5'd2,  1'b0, 3,  32'h13572468);
    for (int i = 0; i < 6; i++) begin
      run_txn((i % 2 == 0) ? 2'b01 : 2'b10, {$urandom_range(0, 255), 2'b00}, $urandom,
              $urandom, 5'($urandom_range(0, 31)), 1'b1, $urandom_range(0, 5), $urandom);
    end

    // Reset in the middle of a bus access, then a stray ack.
    mem_memrw = 2'b01; mem_memaddr = 32'h80; mem_waddr = 5'd10; mem_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bus_req_before_rst", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stall_during_rst", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_bus_addr", bus_addr, 32'd0);
    check("rst_mid_wb_wdata", wb_wdata, 32'd0);
    check("rst_mid_wb_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_memrw = 2'b00; mem_memaddr = '0; mem_waddr = '0; mem_we = 1'b0; mem_wdata = '0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_wb_we", 32'(wb_we), 32'd0);
    check("late_ack_wb_wdata", wb_wdata, 32'd0);
    check("late_ack_bus_req", 32'(bus_req), 32'd0);
    check("late_ack_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;

    run_txn(2'b01, 32'h84, 32'h0, 32'h0, 5'd12, 1'b1, 2, 32'h2468ACE0);
    run_txn(2'b00, 32'h0,  32'h0, 32'h5A5A5A5A, 5'd1, 1'b0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
